alu: RTL and testbench
======================

Name: alu

Overview:
- 16-bit signed arithmetic/logic unit of the pocket-calculator datapath.
- Combines the accumulator with one of the X/Y registers, or combines a register with an immediate value.
- Produces a 16-bit result and 4 status flags combinationally from the current operands, so the control unit can latch them in the same cycle.
- A clocked "ready" state, cleared by reset, gates the outputs.

Parameters:
- WIDTH, 16, datapath width; all rules below are written for 16.

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  reset, synchronous, active-low
- EN  in  1  enable; 0 forces res=0, flags=0
- OPCODE  in  6  operation select
- REGISTER_ADDRESS  in  1  operand register select: 0=X, 1=Y
- ACC  in  16  accumulator (signed)
- X  in  16  register X (signed)
- Y  in  16  register Y (signed)
- IMMEDIATE  in  16  immediate (signed); 0 means "no immediate"
- fact_reg  in  16  factorial running product (unsigned)
- fact_val  in  16  factorial next multiplier (unsigned)
- res  out  16  result (signed)
- flags  out  4  [0]=overflow, [1]=carry/borrow, [2]=negative, [3]=zero

Behaviour:
- Ready register: cleared at any rising CLK edge with RST=0; set at the first rising edge with RST=1. While ready=0, res=0 and flags=0.
- When ready=1 and EN=1, res and flags are purely combinational from the inputs; no clock is required between an input change and a valid output.
- Operand selection:
  - R = X if REGISTER_ADDRESS=0, else Y.
  - If IMMEDIATE != 0: a=R, b=IMMEDIATE.
  - Otherwise: a=ACC, b=R.
- Opcodes (results are the low 16 bits):
  - 000111 ADD: a+b
  - 001000 SUB: a-b
  - 001001 MUL: signed a*b
  - 001010 DIV: signed a/b
  - 001011 MOD: signed a%b
  - 001100 AND, 001101 OR, 001110 XOR: bitwise a op b
  - 001111 NOT: ~a
  - 010000 SHL: a<<b[3:0]
  - 010001 SHR: arithmetic a>>>b[3:0]
  - 010010 CMP: computes a-b and its flags, but res=0
  - 010011 FACT: unsigned fact_reg*fact_val
  - any other opcode: res=0, flags=0
- Flags:
  - zero = (16-bit result == 0); for CMP, taken from the internal difference.
  - negative = result[15].
  - carry, ADD: carry-out of the unsigned 17-bit sum.
  - carry, SUB/CMP: 1 when a < b unsigned (borrow).
  - carry, MUL/FACT: 1 when the full product does not fit in 16 bits (signed for MUL, unsigned for FACT).
  - carry, all other ops: 0.
  - overflow, ADD/SUB/CMP: (a[15]==b[15]) && (result[15]!=a[15]). The same sign rule applies to SUB; b is not inverted.
  - overflow, all other ops: 0.
- Divide by zero (DIV/MOD with b=0): res=0, overflow=1, carry=0.
- DIV of -32768 by -1: res=-32768, overflow=1.
- RST=0 at a clock edge while EN=1: outputs go to 0 immediately after that edge and stay 0 until one clock edge with RST=1.

Decomposition:
- Shared package alu_pkg: opcode localparams (OP_ADD … OP_FACT) and flag bit indices (FLG_OVF=0, FLG_CARRY=1, FLG_NEG=2, FLG_ZERO=3).
- One sub-module, alu_flags: computes the flags from a, b, the 17-bit/32-bit raw result and the op class.

Test Plan:
- Reset low for 3 edges, then RST=1, EN=1; ADD, REG=0, X=6, ACC=0, IMM=0 -> res=6.
- ADD, REG=1, ACC=16'h7FFE, Y=2 -> res=16'h8000, flags[0]=1. Then ACC=3, Y=16'hFFFD -> res=0, flags[1]=1, flags[3]=1. Then Y=16'hFFFC -> res=16'hFFFF, flags[2]=1.
- ADD with IMM=16'h5555, REG=0, X=16'h2AAA -> res=16'h7FFF (ACC ignored). Same with REG=1, Y=16'h83C0, IMM=16'hF83E -> res=16'h7BFE.
- SUB, REG=1, ACC=16'hFFF3, Y=16'h8001 -> res=16'h7FF2, flags[0]=1. Then ACC=Y=3 -> res=0, flags[3]=1. Then ACC=3, Y=16'h38 -> res=16'hFFCB, flags[2]=1.
- SUB with IMM: X=16'hFFFF, IMM=16'hFFF1 -> res=14. Then Y=16'h83C0, IMM=16'h6074 -> res=16'h234C.
- EN=0 or RST=0 mid-operation -> res=0, flags=0. DIV with b=0 -> res=0, flags[0]=1. FACT with fact_reg=24, fact_val=5 -> res=120.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the calculator ALU: opcode encodings, flag bit positions
// and the operation classes used to steer flag generation.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    localparam logic [5:0] OP_ADD  = 6'b000111;
    localparam logic [5:0] OP_SUB  = 6'b001000;
    localparam logic [5:0] OP_MUL  = 6'b001001;
    localparam logic [5:0] OP_DIV  = 6'b001010;
    localparam logic [5:0] OP_MOD  = 6'b001011;
    localparam logic [5:0] OP_AND  = 6'b001100;
    localparam logic [5:0] OP_OR   = 6'b001101;
    localparam logic [5:0] OP_XOR  = 6'b001110;
    localparam logic [5:0] OP_NOT  = 6'b001111;
    localparam logic [5:0] OP_SHL  = 6'b010000;
    localparam logic [5:0] OP_SHR  = 6'b010001;
    localparam logic [5:0] OP_CMP  = 6'b010010;
    localparam logic [5:0] OP_FACT = 6'b010011;

    localparam int FLG_OVF   = 0;
    localparam int FLG_CARRY = 1;
    localparam int FLG_NEG   = 2;
    localparam int FLG_ZERO  = 3;

    // CLS_NONE marks an undefined opcode: all flags are forced low.
    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_ADD,
        CLS_SUB,
        CLS_MUL,
        CLS_FACT,
        CLS_DIV,
        CLS_LOGIC
    } op_class_e;

    function automatic op_class_e op_class(input logic [5:0] op);
        op_class_e cls;
        case (op)
            OP_ADD:                         cls = CLS_ADD;
            OP_SUB, OP_CMP:                 cls = CLS_SUB;
            OP_MUL:                         cls = CLS_MUL;
            OP_FACT:                        cls = CLS_FACT;
            OP_DIV, OP_MOD:                 cls = CLS_DIV;
            OP_AND, OP_OR, OP_XOR, OP_NOT,
            OP_SHL, OP_SHR:                 cls = CLS_LOGIC;
            default:                        cls = CLS_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/alu_flags.sv
// Status flag generation for the ALU from operand signs, raw sum/difference,
// the high part of the product and the (pre-masking) result.
module alu_flags
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             a_msb,
    input  logic             b_msb,
    input  logic [WIDTH:0]   raw_sum,
    input  logic [WIDTH:0]   prod_hi,
    input  logic [WIDTH-1:0] result,
    input  op_class_e        op_cls,
    input  logic             div_ovf,
    output logic [3:0]       flags
);

    // Flag decode per operation class; undefined opcodes leave every flag low.
    always_comb begin
        flags = 4'b0000;
        case (op_cls)
            CLS_ADD, CLS_SUB: begin
                // Same sign rule for add and subtract; raw_sum[WIDTH] is carry or borrow.
                flags[FLG_OVF]   = (a_msb == b_msb) && (raw_sum[WIDTH-1] != a_msb);
                flags[FLG_CARRY] = raw_sum[WIDTH];
            end
            CLS_MUL: begin
                flags[FLG_CARRY] = !((&prod_hi) || !(|prod_hi));
            end
            CLS_FACT: begin
                flags[FLG_CARRY] = |prod_hi[WIDTH:1];
            end
            CLS_DIV: begin
                flags[FLG_OVF] = div_ovf;
            end
            CLS_LOGIC: begin
                flags[FLG_OVF] = 1'b0;
            end
            default: begin
                flags[FLG_OVF] = 1'b0;
            end
        endcase
        if (op_cls != CLS_NONE) begin
            flags[FLG_NEG]  = result[WIDTH-1];
            flags[FLG_ZERO] = (result == {WIDTH{1'b0}});
        end else begin
            flags[FLG_NEG]  = 1'b0;
            flags[FLG_ZERO] = 1'b0;
        end
    end

endmodule

// File: rtl/alu.sv
// 16-bit signed ALU for the calculator datapath: combinational result and flags,
// gated by a reset-cleared ready register and the EN input.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [5:0]       OPCODE,
    input  logic             REGISTER_ADDRESS,
    input  logic [WIDTH-1:0] ACC,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [WIDTH-1:0] IMMEDIATE,
    input  logic [WIDTH-1:0] fact_reg,
    input  logic [WIDTH-1:0] fact_val,
    output logic [WIDTH-1:0] res,
    output logic [3:0]       flags
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};

    logic                    ready_r;
    logic [WIDTH-1:0]        reg_s;
    logic [WIDTH-1:0]        a_s;
    logic [WIDTH-1:0]        b_s;
    logic [WIDTH:0]          sum_s;
    logic [WIDTH:0]          diff_s;
    logic [WIDTH:0]          raw_sum_s;
    logic signed [2*WIDTH-1:0] smul_s;
    logic [2*WIDTH-1:0]      umul_s;
    logic [2*WIDTH-1:0]      prod_s;
    logic [WIDTH-1:0]        quo_s;
    logic [WIDTH-1:0]        rem_s;
    logic                    div_zero_s;
    logic                    div_wrap_s;
    logic                    div_ovf_s;
    logic [WIDTH-1:0]        raw_res_s;
    logic [3:0]              flags_s;
    op_class_e               cls_s;

    // Ready goes low on any edge with RST low and comes back one edge after release.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            ready_r <= 1'b0;
        end else begin
            ready_r <= 1'b1;
        end
    end

    // Operand routing: a nonzero immediate replaces the accumulator path.
    always_comb begin
        reg_s = REGISTER_ADDRESS ? Y : X;
        if (IMMEDIATE != {WIDTH{1'b0}}) begin
            a_s = reg_s;
            b_s = IMMEDIATE;
        end else begin
            a_s = ACC;
            b_s = reg_s;
        end
    end

    assign sum_s  = {1'b0, a_s} + {1'b0, b_s};
    assign diff_s = {1'b0, a_s} - {1'b0, b_s};
    assign smul_s = $signed(a_s) * $signed(b_s);
    assign umul_s = fact_reg * fact_val;
    assign cls_s  = op_class(OPCODE);

    // Signed divide with the two undefined corners (b==0, MIN/-1) resolved explicitly.
    always_comb begin
        div_zero_s = (b_s == {WIDTH{1'b0}});
        div_wrap_s = (a_s == MIN_NEG) && (b_s == ALL_ONE);
        if (div_zero_s) begin
            quo_s = {WIDTH{1'b0}};
            rem_s = {WIDTH{1'b0}};
        end else if (div_wrap_s) begin
            quo_s = MIN_NEG;
            rem_s = {WIDTH{1'b0}};
        end else begin
            quo_s = $signed(a_s) / $signed(b_s);
            rem_s = $signed(a_s) % $signed(b_s);
        end
    end

    // Opcode mux; for CMP the difference drives the flags and is masked from res later.
    always_comb begin
        raw_res_s = {WIDTH{1'b0}};
        raw_sum_s = sum_s;
        prod_s    = smul_s;
        div_ovf_s = 1'b0;
        case (OPCODE)
            OP_ADD:  raw_res_s = sum_s[WIDTH-1:0];
            OP_SUB, OP_CMP: begin
                raw_sum_s = diff_s;
                raw_res_s = diff_s[WIDTH-1:0];
            end
            OP_MUL:  raw_res_s = smul_s[WIDTH-1:0];
            OP_DIV: begin
                raw_res_s = quo_s;
                div_ovf_s = div_zero_s || div_wrap_s;
            end
            OP_MOD: begin
                raw_res_s = rem_s;
                div_ovf_s = div_zero_s;
            end
            OP_AND:  raw_res_s = a_s & b_s;
            OP_OR:   raw_res_s = a_s | b_s;
            OP_XOR:  raw_res_s = a_s ^ b_s;
            OP_NOT:  raw_res_s = ~a_s;
            OP_SHL:  raw_res_s = a_s << b_s[SHW-1:0];
            OP_SHR:  raw_res_s = $signed(a_s) >>> b_s[SHW-1:0];
            OP_FACT: begin
                prod_s    = umul_s;
                raw_res_s = umul_s[WIDTH-1:0];
            end
            default: raw_res_s = {WIDTH{1'b0}};
        endcase
    end

    alu_flags #(.WIDTH(WIDTH)) u_flags (
        .a_msb   (a_s[WIDTH-1]),
        .b_msb   (b_s[WIDTH-1]),
        .raw_sum (raw_sum_s),
        .prod_hi (prod_s[2*WIDTH-1:WIDTH-1]),
        .result  (raw_res_s),
        .op_cls  (cls_s),
        .div_ovf (div_ovf_s),
        .flags   (flags_s)
    );

    // Output gating by ready and enable.
    always_comb begin
        if (ready_r && EN) begin
            res   = (OPCODE == OP_CMP) ? {WIDTH{1'b0}} : raw_res_s;
            flags = flags_s;
        end else begin
            res   = {WIDTH{1'b0}};
            flags = 4'b0000;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the calculator ALU; expected values are hand-computed.
module tb_alu;
    import alu_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        EN = 1'b0;
    logic [5:0]  OPCODE = 6'd0;
    logic        REGISTER_ADDRESS = 1'b0;
    logic [15:0] ACC = 16'd0, X = 16'd0, Y = 16'd0, IMMEDIATE = 16'd0;
    logic [15:0] fact_reg = 16'd0, fact_val = 16'd0;
    logic [15:0] res;
    logic [3:0]  flags;
    int errors = 0;
    int checks = 0;

    alu dut (
        .CLK(CLK), .RST(RST), .EN(EN), .OPCODE(OPCODE),
        .REGISTER_ADDRESS(REGISTER_ADDRESS), .ACC(ACC), .X(X), .Y(Y),
        .IMMEDIATE(IMMEDIATE), .fact_reg(fact_reg), .fact_val(fact_val),
        .res(res), .flags(flags)
    );

    always #5 CLK = ~CLK;

    task automatic drive(input logic [5:0] op, input logic r, input logic [15:0] acc,
                         input logic [15:0] x, input logic [15:0] y, input logic [15:0] imm);
        OPCODE = op; REGISTER_ADDRESS = r; ACC = acc; X = x; Y = y; IMMEDIATE = imm;
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b0; EN = 1'b1;
        drive(OP_ADD, 1'b0, 16'h0000, 16'h0006, 16'h0000, 16'h0000);
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (res !== 16'h0000 || flags !== 4'b0000) begin
            errors++; $display("FAIL reset res=%h flags=%b expected res=0000 flags=0000", res, flags);
        end
        RST = 1'b1;
        @(posedge CLK); #1;
        checks++;
        if (res !== 16'h0006 || flags !== 4'b0000) begin
            errors++; $display("FAIL add_first res=%h flags=%b expected res=0006 flags=0000", res, flags);
        end
    endtask

    task automatic test_add();
        logic [5:0]  op [6];
        logic        r [6];
        logic [15:0] acc [6], x [6], y [6], imm [6], er [6];
        logic [3:0]  ef [6];
        op = '{OP_ADD, OP_ADD, OP_ADD, OP_ADD, OP_ADD, OP_ADD};
        r   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        acc = '{16'h7FFE, 16'h0003, 16'h0003, 16'h1234, 16'h1234, 16'h0002};
        x   = '{16'h0000, 16'h0000, 16'h0000, 16'h2AAA, 16'h0000, 16'h0005};
        y   = '{16'h0002, 16'hFFFD, 16'hFFFC, 16'h0000, 16'h83C0, 16'h0000};
        imm = '{16'h0000, 16'h0000, 16'h0000, 16'h5555, 16'hF83E, 16'h0000};
        er  = '{16'h8000, 16'h0000, 16'hFFFF, 16'h7FFF, 16'h7BFE, 16'h0007};
        ef  = '{4'b0101, 4'b1010, 4'b0100, 4'b0000, 4'b0011, 4'b0000};
        for (int i = 0; i < 6; i++) begin
            drive(op[i], r[i], acc[i], x[i], y[i], imm[i]);
            checks++;
            if (res !== er[i] || flags !== ef[i]) begin
                errors++;
                $display("FAIL add[%0d] res=%h flags=%b expected res=%h flags=%b", i, res, flags, er[i], ef[i]);
            end
        end
    endtask

    task automatic test_sub_cmp();
        logic [5:0]  op [7];
        logic        r [7];
        logic [15:0] acc [7], x [7], y [7], imm [7], er [7];
        logic [3:0]  ef [7];
        op  = '{OP_SUB, OP_SUB, OP_SUB, OP_SUB, OP_SUB, OP_CMP, OP_CMP};
        r   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        acc = '{16'hFFF3, 16'h0003, 16'h0003, 16'h0000, 16'h0000, 16'h0003, 16'h0003};
        x   = '{16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
        y   = '{16'h8001, 16'h0003, 16'h0038, 16'h0000, 16'h83C0, 16'h0038, 16'h0003};
        imm = '{16'h0000, 16'h0000, 16'h0000, 16'hFFF1, 16'h6074, 16'h0000, 16'h0000};
        er  = '{16'h7FF2, 16'h0000, 16'hFFCB, 16'h000E, 16'h234C, 16'h0000, 16'h0000};
        ef  = '{4'b0001, 4'b1000, 4'b0111, 4'b0001, 4'b0000, 4'b0111, 4'b1000};
        for (int i = 0; i < 7; i++) begin
            drive(op[i], r[i], acc[i], x[i], y[i], imm[i]);
            checks++;
            if (res !== er[i] || flags !== ef[i]) begin
                errors++;
                $display("FAIL sub_cmp[%0d] res=%h flags=%b expected res=%h flags=%b", i, res, flags, er[i], ef[i]);
            end
        end
    endtask

    task automatic test_mul_div();
        logic [5:0]  op [6];
        logic [15:0] acc [6], x [6], er [6];
        logic [3:0]  ef [6];
        op  = '{OP_MUL, OP_MUL, OP_DIV, OP_DIV, OP_MOD, OP_MOD};
        acc = '{16'hFFFD, 16'h0100, 16'hFFF9, 16'h8000, 16'hFFF9, 16'h0009};
        x   = '{16'h0005, 16'h0100, 16'h0002, 16'hFFFF, 16'h0002, 16'h0004};
        er  = '{16'hFFF1, 16'h0000, 16'hFFFD, 16'h8000, 16'hFFFF, 16'h0001};
        ef  = '{4'b0100, 4'b1010, 4'b0100, 4'b0101, 4'b0100, 4'b0000};
        for (int i = 0; i < 6; i++) begin
            drive(op[i], 1'b0, acc[i], x[i], 16'h0000, 16'h0000);
            checks++;
            if (res !== er[i] || flags !== ef[i]) begin
                errors++;
                $display("FAIL mul_div[%0d] res=%h flags=%b expected res=%h flags=%b", i, res, flags, er[i], ef[i]);
            end
        end
        drive(OP_DIV, 1'b0, 16'h0005, 16'h0000, 16'h0000, 16'h0000);
        checks++;
        if (res !== 16'h0000 || flags[2:0] !== 3'b001) begin
            errors++; $display("FAIL div_zero res=%h flags=%b expected res=0000 flags[2:0]=001", res, flags);
        end
        drive(OP_MOD, 1'b0, 16'h0005, 16'h0000, 16'h0000, 16'h0000);
        checks++;
        if (res !== 16'h0000 || flags[2:0] !== 3'b001) begin
            errors++; $display("FAIL mod_zero res=%h flags=%b expected res=0000 flags[2:0]=001", res, flags);
        end
    endtask

    task automatic test_logic_shift();
        logic [5:0]  op [8];
        logic [15:0] acc [8], x [8], er [8];
        logic [3:0]  ef [8];
        op  = '{OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR, 6'b000000, 6'b111111};
        acc = '{16'hF0F0, 16'h00F0, 16'hFFFF, 16'h0000, 16'h0001, 16'h8000, 16'h0005, 16'h0005};
        x   = '{16'hFF00, 16'h0F00, 16'hFFFF, 16'h1234, 16'h0013, 16'h0004, 16'h0005, 16'h0005};
        er  = '{16'hF000, 16'h0FF0, 16'h0000, 16'hFFFF, 16'h0008, 16'hF800, 16'h0000, 16'h0000};
        ef  = '{4'b0100, 4'b0000, 4'b1000, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
        for (int i = 0; i < 8; i++) begin
            drive(op[i], 1'b0, acc[i], x[i], 16'h0000, 16'h0000);
            checks++;
            if (res !== er[i] || flags !== ef[i]) begin
                errors++;
                $display("FAIL logic[%0d] res=%h flags=%b expected res=%h flags=%b", i, res, flags, er[i], ef[i]);
            end
        end
    endtask

    task automatic test_fact();
        fact_reg = 16'd24; fact_val = 16'd5;
        drive(OP_FACT, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        checks++;
        if (res !== 16'd120 || flags !== 4'b0000) begin
            errors++; $display("FAIL fact_small res=%h flags=%b expected res=0078 flags=0000", res, flags);
        end
        fact_reg = 16'd1000; fact_val = 16'd1000;
        #1;
        checks++;
        if (res !== 16'h4240 || flags !== 4'b0010) begin
            errors++; $display("FAIL fact_big res=%h flags=%b expected res=4240 flags=0010", res, flags);
        end
    endtask

    task automatic test_enable_reset();
        drive(OP_ADD, 1'b0, 16'h0003, 16'h0003, 16'h0000, 16'h0000);
        EN = 1'b0; #1;
        checks++;
        if (res !== 16'h0000 || flags !== 4'b0000) begin
            errors++; $display("FAIL en_low res=%h flags=%b expected res=0000 flags=0000", res, flags);
        end
        EN = 1'b1; #1;
        checks++;
        if (res !== 16'h0006) begin
            errors++; $display("FAIL en_high res=%h expected res=0006", res);
        end
        @(negedge CLK); RST = 1'b0;
        @(posedge CLK); #1;
        checks++;
        if (res !== 16'h0000 || flags !== 4'b0000) begin
            errors++; $display("FAIL rst_mid res=%h flags=%b expected res=0000 flags=0000", res, flags);
        end
        RST = 1'b1; #2;
        checks++;
        if (res !== 16'h0000) begin
            errors++; $display("FAIL rst_hold res=%h expected res=0000", res);
        end
        @(posedge CLK); #1;
        checks++;
        if (res !== 16'h0006) begin
            errors++; $display("FAIL rst_recover res=%h expected res=0006", res);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_cmp();
        test_mul_div();
        test_logic_shift();
        test_fact();
        test_enable_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
